// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM state type and byte-enable helper for the MEM stage.
// Rev 1.0
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_byte(input logic [2:0] funct3);
    return (funct3 == F3_B) || (funct3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] funct3);
    return (funct3 == F3_H) || (funct3 == F3_HU);
  endfunction

  // Reserved encodings fall through to a full-word enable.
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
    if (is_byte(funct3))
      return 4'b0001 << off;
    else if (is_half(funct3))
      return off[1] ? 4'b1100 : 4'b0011;
    else
      return 4'b1111;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a read word and sign/zero extends it.
// Rev 1.0
`default_nettype none

module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage -- DMEM req/ack handshake, front-of-pipe stall, MEM/WB register.
// Rev 1.0
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stage_EX_MEM__MEM_valid,
  input  logic                  stage_EX_MEM__MEM_memread,
  input  logic                  stage_EX_MEM__MEM_memwrite,
  input  logic                  stage_EX_MEM__MEM_memtoreg,
  input  logic                  stage_EX_MEM__MEM_regwrite,
  input  logic [2:0]            stage_EX_MEM__MEM_funct3,
  input  logic [31:0]           stage_EX_MEM__MEM_alu_result,
  input  logic [DATA_WIDTH-1:0] stage_EX_MEM__MEM_store_data,
  input  logic [4:0]            stage_EX_MEM__MEM_rd_id,
  output logic                  MEM__DMEM_req,
  output logic                  MEM__DMEM_we,
  output logic [ADDR_WIDTH-1:0] MEM__DMEM_addr,
  output logic [DATA_WIDTH-1:0] MEM__DMEM_wdata,
  output logic [3:0]            MEM__DMEM_be,
  input  logic                  DMEM__MEM_ack,
  input  logic [DATA_WIDTH-1:0] DMEM__MEM_rdata,
  output logic                  MEM__HZ_stall,
  output logic                  MEM__EXC_misalign,
  output logic                  stage_MEM_WB__WB_memtoreg,
  output logic                  stage_MEM_WB__WB_regwrite,
  output logic [DATA_WIDTH-1:0] stage_MEM_WB__WB_memdata,
  output logic [31:0]           stage_MEM_WB__WB_regdata,
  output logic [4:0]            stage_MEM_WB__WB_rd_id
);

  state_t                state, state_next;
  logic                  mem_op, is_load, misaligned, accept, misalign_det;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic                  regwrite_q;
  logic [DATA_WIDTH-1:0] store_rep, load_data;

  assign mem_op  = stage_EX_MEM__MEM_valid &
                   (stage_EX_MEM__MEM_memread | stage_EX_MEM__MEM_memwrite);
  assign is_load = stage_EX_MEM__MEM_memread;

  always_comb begin
    misaligned = 1'b0;
    if (is_half(stage_EX_MEM__MEM_funct3))
      misaligned = stage_EX_MEM__MEM_alu_result[0];
    else if (!is_byte(stage_EX_MEM__MEM_funct3))
      misaligned = |stage_EX_MEM__MEM_alu_result[1:0];
  end

  // Replicate the store operand across lanes so memory only has to honour be.
  always_comb begin
    if (is_byte(stage_EX_MEM__MEM_funct3))
      store_rep = {4{stage_EX_MEM__MEM_store_data[7:0]}};
    else if (is_half(stage_EX_MEM__MEM_funct3))
      store_rep = {2{stage_EX_MEM__MEM_store_data[15:0]}};
    else
      store_rep = stage_EX_MEM__MEM_store_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    MEM__HZ_stall = 1'b0;
    accept        = 1'b0;
    misalign_det  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            misalign_det = 1'b1;
          end else begin
            accept        = 1'b1;
            MEM__HZ_stall = 1'b1;
            state_next    = BUSY;
          end
        end
      end
      BUSY: begin
        MEM__HZ_stall = !DMEM__MEM_ack;
        if (DMEM__MEM_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .rdata  (DMEM__MEM_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MEM__DMEM_req             <= 1'b0;
      MEM__DMEM_we              <= 1'b0;
      MEM__DMEM_addr            <= '0;
      MEM__DMEM_wdata           <= '0;
      MEM__DMEM_be              <= '0;
      f3_q                      <= '0;
      off_q                     <= '0;
      rd_q                      <= '0;
      regwrite_q                <= 1'b0;
      MEM__EXC_misalign         <= 1'b0;
      stage_MEM_WB__WB_memtoreg <= 1'b0;
      stage_MEM_WB__WB_regwrite <= 1'b0;
      stage_MEM_WB__WB_memdata  <= '0;
      stage_MEM_WB__WB_regdata  <= '0;
      stage_MEM_WB__WB_rd_id    <= '0;
    end else begin
      MEM__EXC_misalign         <= misalign_det;
      // Bubble unless a result is actually retired this edge.
      stage_MEM_WB__WB_memtoreg <= 1'b0;
      stage_MEM_WB__WB_regwrite <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          MEM__DMEM_req   <= 1'b1;
          MEM__DMEM_we    <= !is_load;
          MEM__DMEM_addr  <= {stage_EX_MEM__MEM_alu_result[ADDR_WIDTH-1:2], 2'b00};
          MEM__DMEM_wdata <= store_rep;
          MEM__DMEM_be    <= is_load ? 4'b1111 :
                             be_for(stage_EX_MEM__MEM_funct3, stage_EX_MEM__MEM_alu_result[1:0]);
          f3_q            <= stage_EX_MEM__MEM_funct3;
          off_q           <= stage_EX_MEM__MEM_alu_result[1:0];
          rd_q            <= stage_EX_MEM__MEM_rd_id;
          regwrite_q      <= stage_EX_MEM__MEM_regwrite;
        end else if (!mem_op) begin
          stage_MEM_WB__WB_regdata  <= stage_EX_MEM__MEM_alu_result;
          stage_MEM_WB__WB_rd_id    <= stage_EX_MEM__MEM_rd_id;
          stage_MEM_WB__WB_memtoreg <= stage_EX_MEM__MEM_memtoreg;
          stage_MEM_WB__WB_regwrite <= stage_EX_MEM__MEM_regwrite & stage_EX_MEM__MEM_valid;
        end
      end else if (DMEM__MEM_ack) begin
        MEM__DMEM_req <= 1'b0;
        if (!MEM__DMEM_we) begin
          stage_MEM_WB__WB_memdata  <= load_data;
          stage_MEM_WB__WB_rd_id    <= rd_q;
          stage_MEM_WB__WB_memtoreg <= 1'b1;
          stage_MEM_WB__WB_regwrite <= regwrite_q;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 5-stage core. Sits between the EX/MEM pipeline register and the write-back stage. It issues load/store requests to the data memory over a req/ack handshake and stalls the front of the pipe while an access is outstanding. It also formats load data (byte/half, sign/zero extension) and registers the results into the MEM/WB fields that feed write-back.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data-path width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte-address width.

Ports:
- `clk`  in  1  — the block's single clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `stage_EX_MEM__MEM_valid`  in  1  — EX/MEM slot holds a real instruction.
- `stage_EX_MEM__MEM_memread` / `_memwrite`  in  1 each  — load / store.
- `stage_EX_MEM__MEM_memtoreg` / `_regwrite`  in  1 each  — passed through to WB.
- `stage_EX_MEM__MEM_funct3`  in  3  — access size and signedness.
- `stage_EX_MEM__MEM_alu_result`  in  32  — byte address, or register result for non-memory instructions.
- `stage_EX_MEM__MEM_store_data`  in  DATA_WIDTH  — rs2 value.
- `stage_EX_MEM__MEM_rd_id`  in  5  — destination register.
- `MEM__DMEM_req`  out  1  — request valid.
- `MEM__DMEM_we`  out  1  — 1 = store.
- `MEM__DMEM_addr`  out  ADDR_WIDTH  — word-aligned address; bits [1:0] are 0.
- `MEM__DMEM_wdata`  out  DATA_WIDTH  — lane-replicated store data.
- `MEM__DMEM_be`  out  4  — byte enables.
- `DMEM__MEM_ack`  in  1  — access complete; `rdata` is valid in the same cycle.
- `DMEM__MEM_rdata`  in  DATA_WIDTH  — read word.
- `MEM__HZ_stall`  out  1  — hold EX/MEM and all earlier stages.
- `MEM__EXC_misalign`  out  1  — one-cycle pulse, registered.
- `stage_MEM_WB__WB_memtoreg`, `_regwrite`  out  1 each  — registered.
- `stage_MEM_WB__WB_memdata`  out  DATA_WIDTH  — registered.
- `stage_MEM_WB__WB_regdata`  out  32  — registered.
- `stage_MEM_WB__WB_rd_id`  out  5  — registered.

## Operation
- FSM has two states, IDLE and BUSY. Reset enters IDLE.
- A memory op is `valid & (memread | memwrite)`. If both bits are set, it is treated as a load.
- **Alignment:**
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Reserved funct3 encodings are treated as word accesses.
- **IDLE, non-memory op or `valid`=0:**
  - At the edge, MEM/WB loads `regdata`=`alu_result`, `rd_id`, `memtoreg`, and `regwrite & valid`.
  - No stall.
- **IDLE, misaligned memory op:**
  - No request is issued.
  - MEM/WB loads a bubble (`regwrite`=0, `memtoreg`=0).
  - `MEM__EXC_misalign` pulses for one cycle.
  - No stall.
- **IDLE, aligned memory op:**
  - `MEM__HZ_stall`=1 combinationally.
  - Address, we, be, wdata, funct3, byte offset, rd_id and control bits are latched.
  - MEM/WB loads a bubble. State goes to BUSY.
- **BUSY:**
  - `req`=1 and request fields are held stable until ack.
  - `stall` = !ack.
  - On ack:
    - Loads: MEM/WB loads formatted `memdata`, latched `rd_id`, `memtoreg`=1 and `regwrite`=latched value.
    - Stores: MEM/WB loads `regwrite`=0.
    - `req` drops at that edge and state returns to IDLE.
- **Store formatting:**
  - SB: `be` = 1<<off; wdata = byte replicated ×4.
  - SH: `be` = 0011 or 1100; half replicated ×2.
  - SW: `be` = 1111.
  - Loads drive `be`=1111.
- **Load formatting:**
  - LB/LBU select byte[off]; LH/LHU select half[off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- An ack received while in IDLE is ignored.
- **Reset (including mid-BUSY):**
  - Next edge: state IDLE, `req`=0, `stall`=0.
  - All registered outputs are 0; `misalign`=0.
  - Any outstanding ack is discarded.

## Timing
- Non-memory op: 1 cycle from EX/MEM to MEM/WB.
- Memory op: stall is high from the accept cycle through the cycle before ack.
- `req` first rises the cycle after accept.
- Result reaches MEM/WB at the ack edge. Minimum latency is 2 cycles when ack is returned in the first req cycle.
- `stall` drops combinationally in the ack cycle, so EX/MEM advances on that same edge with zero bubble after completion.
- `MEM__DMEM_*` outputs are registered. The only combinational paths are ack→stall and valid/memread/memwrite/addr→stall.

## Structure
- Package `mem_pkg` holds:
  - funct3 localparams (`F3_B`/`H`/`W`/`BU`/`HU`).
  - State enum {IDLE, BUSY}.
  - A `be_for(funct3, off)` function.
- Sub-module `mem_load_align` (combinational): inputs rdata, funct3, off; output extended data. It is reused by the bench model.

## Test plan
- Store then load: SW 0xDEADBEEF @0x100, ack after 3 cycles → `be`=1111, stall held 3 cycles. Then LB @0x103 → memdata 0xFFFFFFDE; LBU @0x103 → 0x000000DE.
- SH 0x1234 @0x102 → `be`=1100, wdata 0x12341234. Then LH @0x102 → memdata 0x00001234, `regwrite`=1, `rd_id` matches.
- Misaligned LW @0x101 → no `req`, misalign pulse 1 cycle, MEM/WB `regwrite`=0, no stall.
- Back-to-back: ADD, LW (same-cycle ack), ADD → MEM/WB sequence: add result, bubble, load data, add result. EX/MEM advances on the ack edge.
- `rst_n`=0 during BUSY with ack arriving one cycle later → state IDLE, `req`=0, all MEM/WB outputs 0, late ack ignored.
